// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and default geometry.
package async_fifo_pkg;

    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned AW        = $clog2(DEF_DEPTH);
    localparam int unsigned CONV_W    = 32;

    // Width-generic through zero extension; w masks off bits above the pointer width.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b,
                                                   input int unsigned       w);
        logic [CONV_W-1:0] mask;
        mask = (CONV_W'(1) << w) - CONV_W'(1);
        return (b ^ (b >> 1)) & mask;
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g,
                                                   input int unsigned       w);
        logic [CONV_W-1:0] b;
        logic [CONV_W-1:0] mask;
        mask = (CONV_W'(1) << w) - CONV_W'(1);
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b & mask;
    endfunction

endpackage

// File: rtl/dual_port_RAM.sv
// Simple dual-port RAM: write port on wclk, registered read port on rclk with enable.
module dual_port_RAM #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     wclk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     ren,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ptr_sync.sv
// Multi-stage synchroniser carrying a Gray-coded pointer into the destination clock.
module ptr_sync #(
    parameter int unsigned W      = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with Gray pointer CDC, fill levels, almost flags, error pulses and optional FWFT.
module async_fifo_lvl
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_MARGIN   = 2,
    parameter int unsigned AE_MARGIN   = 2,
    parameter int unsigned FWFT        = 0
) (
    input  logic                     wclk,
    input  logic                     wrstn,
    input  logic                     rclk,
    input  logic                     rrstn,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     wfull,
    output logic                     walmost_full,
    output logic [$clog2(DEPTH):0]   wlevel,
    output logic                     woverflow,
    input  logic                     rinc,
    output logic                     rempty,
    output logic                     ralmost_empty,
    output logic [$clog2(DEPTH):0]   rlevel,
    output logic [WIDTH-1:0]         rdata,
    output logic                     runderflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PW     = ADDR_W + 1;

    // Write domain
    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PW-1:0] rq_gray, rq_bin;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d, walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;
    logic          wr_acc;

    // Read domain
    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PW-1:0] wq_gray, wq_bin;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d;
    logic          runderflow_q, runderflow_d;
    logic          valid_q, valid_d;
    logic          pop, ram_avail, ram_ren;

    ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk   (wclk),
        .rst_n (wrstn),
        .din   (rgray_q),
        .dout  (rq_gray)
    );

    ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk   (rclk),
        .rst_n (rrstn),
        .din   (wgray_q),
        .dout  (wq_gray)
    );

    dual_port_RAM #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .wclk   (wclk),
        .wen    (wr_acc),
        .waddr  (wbin_q[ADDR_W-1:0]),
        .wdata  (wdata),
        .rclk   (rclk),
        .rrst_n (rrstn),
        .ren    (ram_ren),
        .raddr  (rbin_q[ADDR_W-1:0]),
        .rdata  (rdata)
    );

    // Flags use the post-write pointer so a full FIFO never accepts another word.
    always_comb begin
        wr_acc         = winc && !wfull_q;
        wbin_d         = wbin_q + PW'(wr_acc);
        wgray_d        = PW'(bin2gray(CONV_W'(wbin_d), PW));
        rq_bin         = PW'(gray2bin(CONV_W'(rq_gray), PW));
        wlevel_d       = wbin_d - rq_bin;
        wfull_d        = (wlevel_d == PW'(DEPTH));
        walmost_full_d = ((PW'(DEPTH) - wlevel_d) <= PW'(AF_MARGIN));
        woverflow_d    = winc && wfull_q;
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    // In FWFT mode the RAM read register doubles as the one-word output register.
    always_comb begin
        wq_bin       = PW'(gray2bin(CONV_W'(wq_gray), PW));
        pop          = rinc && !rempty_q;
        runderflow_d = rinc && rempty_q;
        ram_avail    = (wq_bin != rbin_q);
        ram_ren      = pop;
        valid_d      = 1'b0;
        if (FWFT != 0) begin
            ram_ren = ram_avail && (!valid_q || pop);
            valid_d = ram_ren || (valid_q && !pop);
        end
        rbin_d   = rbin_q + PW'(ram_ren);
        rgray_d  = PW'(bin2gray(CONV_W'(rbin_d), PW));
        rlevel_d = wq_bin - rbin_d;
        rempty_d = (rlevel_d == '0);
        if (FWFT != 0) begin
            rlevel_d = rlevel_d + PW'(valid_d);
            rempty_d = !valid_d;
        end
        ralmost_empty_d = (rlevel_d <= PW'(AE_MARGIN));
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            runderflow_q    <= runderflow_d;
            valid_q         <= valid_d;
        end
    end

    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign wlevel        = wlevel_q;
    assign woverflow     = woverflow_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed bench: standard-read FIFO (instance a) and FWFT FIFO (instance b) on shared clocks.
`timescale 1ns/100ps
module tb_async_fifo_lvl;

    logic       wclk, rclk, wrstn, rrstn;
    logic       winc, rinc, winc_b, rinc_b;
    logic [7:0] wdata, wdata_b, rdata, rdata_b;
    logic       wfull, walmost_full, woverflow, rempty, ralmost_empty, runderflow;
    logic       wfull_b, walmost_full_b, woverflow_b, rempty_b, ralmost_empty_b, runderflow_b;
    logic [4:0] wlevel, rlevel, wlevel_b, rlevel_b;

    int vecs = 0;
    int miscompares = 0;
    int wr_n, rd_n, wguard, rguard, k;

    async_fifo_lvl #(.WIDTH(8), .DEPTH(16), .SYNC_STAGES(2), .AF_MARGIN(2),
                     .AE_MARGIN(2), .FWFT(0)) u_dut_a (
        .wclk(wclk), .wrstn(wrstn), .rclk(rclk), .rrstn(rrstn),
        .winc(winc), .wdata(wdata), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow), .rinc(rinc), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rdata(rdata),
        .runderflow(runderflow)
    );

    async_fifo_lvl #(.WIDTH(8), .DEPTH(16), .SYNC_STAGES(2), .AF_MARGIN(2),
                     .AE_MARGIN(2), .FWFT(1)) u_dut_b (
        .wclk(wclk), .wrstn(wrstn), .rclk(rclk), .rrstn(rrstn),
        .winc(winc_b), .wdata(wdata_b), .wfull(wfull_b), .walmost_full(walmost_full_b),
        .wlevel(wlevel_b), .woverflow(woverflow_b), .rinc(rinc_b), .rempty(rempty_b),
        .ralmost_empty(ralmost_empty_b), .rlevel(rlevel_b), .rdata(rdata_b),
        .runderflow(runderflow_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;
    initial rclk = 1'b0;
    always #8.5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [7:0] d);
        winc = 1'b1;
        wdata = d;
        @(posedge wclk);
        #1;
        winc = 1'b0;
    endtask

    task automatic rd_a();
        rinc = 1'b1;
        @(posedge rclk);
        #1;
        rinc = 1'b0;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_rempty"}, 32'(rempty), 32'd1);
        chk({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
        chk({tag, "_wfull"}, 32'(wfull), 32'd0);
        chk({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
        chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_woverflow"}, 32'(woverflow), 32'd0);
        chk({tag, "_runderflow"}, 32'(runderflow), 32'd0);
    endtask

    initial begin
        winc = 0; rinc = 0; wdata = 0; winc_b = 0; rinc_b = 0; wdata_b = 0;
        wrstn = 1'b1; rrstn = 1'b1;
        #1;
        wrstn = 1'b0; rrstn = 1'b0;
        #40;
        chk_reset_a("rst");
        chk("rst_b_rempty", 32'(rempty_b), 32'd1);
        chk("rst_b_rdata", 32'(rdata_b), 32'd0);
        wrstn = 1'b1; rrstn = 1'b1;
        repeat (4) @(posedge rclk);
        @(posedge wclk); #1;
        chk_reset_a("post_rst");

        // Fill 16 words, watching level and almost-full thresholds
        for (int i = 0; i < 16; i++) begin
            wr_a(8'(i));
            chk("fill_wlevel", 32'(wlevel), 32'(i + 1));
            if (i == 12) chk("af_at_13", 32'(walmost_full), 32'd0);
            if (i == 13) chk("af_at_14", 32'(walmost_full), 32'd1);
        end
        chk("full_after_16", 32'(wfull), 32'd1);
        wr_a(8'hAA);
        chk("overflow_pulse", 32'(woverflow), 32'd1);
        chk("wlevel_hold", 32'(wlevel), 32'd16);
        @(posedge wclk); #1;
        chk("overflow_clear", 32'(woverflow), 32'd0);

        k = 0;
        while (rlevel != 5'd16 && k < 10) begin
            @(posedge rclk); #1;
            k++;
        end
        chk("rlevel_full", 32'(rlevel), 32'd16);
        chk("rempty_full", 32'(rempty), 32'd0);
        chk("ralmost_empty_full", 32'(ralmost_empty), 32'd0);

        // Drain in order; 0xAA must never appear
        @(posedge rclk); #1;
        for (int i = 0; i < 16; i++) begin
            rd_a();
            chk("drain_data", 32'(rdata), 32'(i));
        end
        chk("drain_rempty", 32'(rempty), 32'd1);
        chk("drain_rlevel", 32'(rlevel), 32'd0);
        rd_a();
        chk("underflow_pulse", 32'(runderflow), 32'd1);
        chk("underflow_rdata", 32'(rdata), 32'h0F);
        @(posedge rclk); #1;
        chk("underflow_clear", 32'(runderflow), 32'd0);
        repeat (6) @(posedge wclk);
        #1;
        chk("wside_empty_wlevel", 32'(wlevel), 32'd0);
        chk("wside_empty_wfull", 32'(wfull), 32'd0);

        // Streaming: 100 words with random read gaps, pointers wrap several times
        wr_n = 0; rd_n = 0; wguard = 0; rguard = 0;
        fork
            begin
                @(posedge wclk); #1;
                while (wr_n < 100 && wguard < 5000) begin
                    winc = !wfull;
                    wdata = 8'(wr_n);
                    @(posedge wclk); #1;
                    if (winc) begin
                        wr_n++;
                        chk("stream_wlevel_max", 32'(wlevel <= 5'd16), 32'd1);
                    end
                    wguard++;
                end
                winc = 1'b0;
            end
            begin
                @(posedge rclk); #1;
                while (rd_n < 100 && rguard < 5000) begin
                    rinc = ($urandom_range(0, 2) != 0) && !rempty;
                    @(posedge rclk); #1;
                    if (rinc) begin
                        chk("stream_data", 32'(rdata), 32'(8'(rd_n)));
                        chk("stream_rlevel_max", 32'(rlevel <= 5'd16), 32'd1);
                        rd_n++;
                    end
                    rguard++;
                end
                rinc = 1'b0;
            end
        join
        chk("stream_writes", 32'(wr_n), 32'd100);
        chk("stream_reads", 32'(rd_n), 32'd100);
        @(posedge rclk); #1;
        chk("stream_end_rempty", 32'(rempty), 32'd1);

        // FWFT instance: head word appears without rinc
        winc_b = 1'b1; wdata_b = 8'h5C;
        @(posedge wclk); #1;
        winc_b = 1'b0;
        k = 0;
        while (rempty_b && k < 4) begin
            @(posedge rclk); #1;
            k++;
        end
        chk("fwft_rempty_fall", 32'(rempty_b), 32'd0);
        chk("fwft_rdata", 32'(rdata_b), 32'h5C);
        chk("fwft_rlevel", 32'(rlevel_b), 32'd1);
        rinc_b = 1'b1;
        @(posedge rclk); #1;
        rinc_b = 1'b0;
        chk("fwft_pop_rempty", 32'(rempty_b), 32'd1);
        chk("fwft_pop_rlevel", 32'(rlevel_b), 32'd0);

        // Reset with 9 words stored, then reuse
        for (int i = 0; i < 9; i++) wr_a(8'(8'h40 + i));
        repeat (5) @(posedge rclk);
        #1;
        chk("nine_rlevel", 32'(rlevel), 32'd9);
        wrstn = 1'b0; rrstn = 1'b0;
        #3;
        chk_reset_a("rst2");
        #30;
        wrstn = 1'b1; rrstn = 1'b1;
        repeat (4) @(posedge rclk);
        @(posedge wclk); #1;
        chk_reset_a("post_rst2");
        wr_a(8'h01);
        wr_a(8'h02);
        k = 0;
        while (rlevel != 5'd2 && k < 10) begin
            @(posedge rclk); #1;
            k++;
        end
        chk("after_rst_rlevel", 32'(rlevel), 32'd2);
        rd_a();
        chk("after_rst_data0", 32'(rdata), 32'h01);
        rd_a();
        chk("after_rst_data1", 32'(rdata), 32'h02);
        chk("after_rst_rempty", 32'(rempty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
